// File: rtl/interleaver_pkg.sv
// ============================================================================
// Module   : interleaver_pkg
// Brief    : Shared state encoding and geometry helpers for the interleaver
//            sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package interleaver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } iseq_state_t;

  function automatic int calc_n(input int p, input int fo, input int z);
    return (p * fo) / z;
  endfunction

  function automatic int calc_iw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_lpz(input int p, input int z);
    return (p == z) ? 1 : $clog2(p / z);
  endfunction

  function automatic int calc_sw(input int p, input int fo, input int z);
    return calc_lpz(p, z) * fo * z;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sweepstart_regfile.sv
// ============================================================================
// Module   : sweepstart_regfile
// Brief    : Serially loaded sweepstart chunk array with wrap-around write
//            pointer and a sticky loaded flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sweepstart_regfile #(
  parameter int NCH   = 16,
  parameter int LPZ   = 2,
  parameter bit STORE = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_wr_en,
  input  logic [LPZ-1:0]     i_wr_data,
  output logic [NCH*LPZ-1:0] o_sweepstart,
  output logic               o_cfg_loaded
);

  if (STORE) begin : g_store
    localparam int c_cw = (NCH > 1) ? $clog2(NCH) : 1;

    logic [LPZ-1:0]  r_mem [NCH];
    logic [c_cw-1:0] r_ccnt;
    logic            r_loaded;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < NCH; k++) r_mem[k] <= '0;
        r_ccnt   <= '0;
        r_loaded <= 1'b0;
      end else if (i_wr_en) begin
        r_mem[r_ccnt] <= i_wr_data;
        // loaded stays set across reloads; only reset clears it
        if (r_ccnt == c_cw'(NCH - 1)) begin
          r_ccnt   <= '0;
          r_loaded <= 1'b1;
        end else begin
          r_ccnt <= r_ccnt + 1'b1;
        end
      end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_flat
      assign o_sweepstart[k*LPZ +: LPZ] = r_mem[k];
    end

    assign o_cfg_loaded = r_loaded;
  end else begin : g_nostore
    logic w_unused;
    assign w_unused     = ^{clk, reset_n, i_wr_en, i_wr_data};
    assign o_sweepstart = '0;
    assign o_cfg_loaded = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/interleaver_sequencer.sv
// ============================================================================
// Module   : interleaver_sequencer
// Brief    : Junction-pass sequencer: steps eff_cycle_index under datapath
//            flow control and owns the run-time loaded sweepstart pattern.
// Revision : 1.0
// ============================================================================
`default_nettype none

module interleaver_sequencer
  import interleaver_pkg::*;
#(
  parameter int P     = 32,
  parameter int FO    = 2,
  parameter int Z     = 8,
  parameter int DRAIN = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                cfg_valid,
  input  logic [calc_lpz(P, Z)-1:0]           cfg_data,
  output logic                                cfg_ready,
  output logic                                cfg_loaded,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                advance,
  output logic [calc_iw(calc_n(P, FO, Z))-1:0] eff_cycle_index,
  output logic                                idx_valid,
  output logic                                first_cycle,
  output logic                                last_cycle,
  output logic                                busy,
  output logic                                done,
  output logic [calc_sw(P, FO, Z)-1:0]        sweepstart
);

  localparam int         c_n          = calc_n(P, FO, Z);
  localparam int         c_iw         = calc_iw(c_n);
  localparam int         c_lpz        = calc_lpz(P, Z);
  localparam int         c_nch        = FO * Z;
  localparam bit         c_store      = (P != Z);
  localparam logic [3:0] c_drain_last = 4'((DRAIN > 0) ? DRAIN - 1 : 0);

  iseq_state_t     r_state, w_state_nx;
  logic [c_iw-1:0] r_idx, w_idx_nx;
  logic [3:0]      r_dcnt, w_dcnt_nx;
  logic            w_idx_last;
  logic            w_cfg_wr;

  assign w_idx_last = (r_idx == c_iw'(c_n - 1));
  assign cfg_ready  = (r_state == ST_IDLE) && c_store;
  assign w_cfg_wr   = cfg_valid && cfg_ready;

  sweepstart_regfile #(
    .NCH   (c_nch),
    .LPZ   (c_lpz),
    .STORE (c_store)
  ) u_regfile (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_wr_en      (w_cfg_wr),
    .i_wr_data    (cfg_data),
    .o_sweepstart (sweepstart),
    .o_cfg_loaded (cfg_loaded)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_dcnt  <= w_dcnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_dcnt_nx  = r_dcnt;
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nx = ST_IDLE;
      w_idx_nx   = '0;
      w_dcnt_nx  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // a same-cycle config write takes priority over start
          if (start && cfg_loaded && !cfg_valid) begin
            w_state_nx = ST_RUN;
            w_idx_nx   = '0;
          end
        end
        ST_RUN: begin
          if (advance) begin
            if (w_idx_last) begin
              w_idx_nx   = '0;
              w_dcnt_nx  = '0;
              w_state_nx = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
            end else begin
              w_idx_nx = r_idx + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (r_dcnt == c_drain_last) begin
            w_dcnt_nx  = '0;
            w_state_nx = ST_DONE;
          end else begin
            w_dcnt_nx = r_dcnt + 1'b1;
          end
        end
        ST_DONE: w_state_nx = ST_IDLE;
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  assign eff_cycle_index = r_idx;
  assign idx_valid       = (r_state == ST_RUN);
  assign first_cycle     = idx_valid && (r_idx == '0);
  assign last_cycle      = idx_valid && w_idx_last;
  assign busy            = (r_state != ST_IDLE);
  assign done            = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_interleaver_sequencer.sv
// ============================================================================
// Module   : tb_interleaver_sequencer
// Brief    : Scoreboard bench for interleaver_sequencer (32/2/8, DRAIN=2)
//            plus a p==z instance for the no-storage configuration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_interleaver_sequencer;

  logic        clk;
  logic        reset_n;
  logic        cfg_valid;
  logic [1:0]  cfg_data;
  logic        cfg_ready;
  logic        cfg_loaded;
  logic        start;
  logic        abort;
  logic        advance;
  logic [2:0]  eff_cycle_index;
  logic        idx_valid;
  logic        first_cycle;
  logic        last_cycle;
  logic        busy;
  logic        done;
  logic [31:0] sweepstart;

  logic        z_cfg_ready;
  logic        z_cfg_loaded;
  logic [0:0]  z_idx;
  logic        z_idx_valid;
  logic        z_first;
  logic        z_last;
  logic        z_busy;
  logic        z_done;
  logic [15:0] z_sweepstart;

  int n_cmp = 0;
  int n_err = 0;
  int sb_q[$];

  interleaver_sequencer #(.P(32), .FO(2), .Z(8), .DRAIN(2)) dut (
    .clk (clk), .reset_n (reset_n),
    .cfg_valid (cfg_valid), .cfg_data (cfg_data), .cfg_ready (cfg_ready),
    .cfg_loaded (cfg_loaded), .start (start), .abort (abort), .advance (advance),
    .eff_cycle_index (eff_cycle_index), .idx_valid (idx_valid),
    .first_cycle (first_cycle), .last_cycle (last_cycle),
    .busy (busy), .done (done), .sweepstart (sweepstart)
  );

  interleaver_sequencer #(.P(8), .FO(2), .Z(8), .DRAIN(2)) dut_pz (
    .clk (clk), .reset_n (reset_n),
    .cfg_valid (1'b0), .cfg_data (1'b0), .cfg_ready (z_cfg_ready),
    .cfg_loaded (z_cfg_loaded), .start (1'b0), .abort (1'b0), .advance (1'b0),
    .eff_cycle_index (z_idx), .idx_valid (z_idx_valid),
    .first_cycle (z_first), .last_cycle (z_last),
    .busy (z_busy), .done (z_done), .sweepstart (z_sweepstart)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_chunk(input logic [1:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  // mode 0: advance held high; mode 1: advance on every other RUN cycle
  task automatic run_pass(input int mode, input int exp_done);
    bit seen_done = 0;
    bit phase     = 0;
    bit adv;
    int exp_idx;
    for (int i = 0; i < 8; i++) sb_q.push_back(i);
    start   = 1'b1;
    advance = 1'b0;
    for (int c = 1; c <= 40 && !seen_done; c++) begin
      tick();
      start = 1'b0;
      if (c == 1) chk_val("ready_while_busy", cfg_ready, 0);
      if (done) begin
        seen_done = 1;
        chk_val("done_cycle", c, exp_done);
      end
      if (idx_valid) begin
        adv     = (mode == 0) ? 1'b1 : phase;
        phase   = ~phase;
        advance = adv;
        if (adv) begin
          if (sb_q.size() == 0) begin
            chk_val("sb_underflow", 1, 0);
          end else begin
            exp_idx = sb_q.pop_front();
            chk_val("index", eff_cycle_index, exp_idx);
            chk_val("first_cycle", first_cycle, exp_idx == 0);
            chk_val("last_cycle", last_cycle, exp_idx == 7);
          end
        end
      end else begin
        advance = 1'b0;
      end
    end
    advance = 1'b0;
    if (!seen_done) chk_val("done_timeout", 0, 1);
    chk_val("sb_leftover", sb_q.size(), 0);
    sb_q.delete();
    tick();
    chk_val("busy_after_done", busy, 0);
    chk_val("done_one_cycle", done, 0);
  endtask

  // run until index reaches target with advance high; returns 1 on success
  task automatic run_to_index(input int target, output bit found);
    found   = 0;
    start   = 1'b1;
    advance = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      start   = 1'b0;
      advance = 1'b1;
      if (idx_valid && eff_cycle_index == 3'(target)) found = 1;
    end
    if (!found) chk_val("reach_index_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit any_done;
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    start     = 1'b0;
    abort     = 1'b0;
    advance   = 1'b0;
    tick();
    tick();
    chk_val("rst_busy", busy, 0);
    chk_val("rst_idx_valid", idx_valid, 0);
    chk_val("rst_index", eff_cycle_index, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_first_last", {first_cycle, last_cycle}, 0);
    chk_val("rst_cfg_ready", cfg_ready, 1);
    chk_val("rst_cfg_loaded", cfg_loaded, 0);
    chk_val("rst_sweepstart", sweepstart, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // start is ignored before the pattern is loaded
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk_val("start_unloaded_busy", busy, 0);
    chk_val("start_unloaded_idx_valid", idx_valid, 0);

    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk_val("loaded_before_last", cfg_loaded, 0);
      load_chunk(2'(k % 4));
    end
    chk_val("loaded_after_16", cfg_loaded, 1);
    chk_val("pattern", sweepstart, 32'he4e4e4e4);

    run_pass(0, 11);
    run_pass(1, 19);

    // abort at index 5: idle next cycle, index cleared, no done
    run_to_index(5, found);
    abort = 1'b1;
    tick();
    abort   = 1'b0;
    advance = 1'b0;
    chk_val("abort_busy", busy, 0);
    chk_val("abort_idx_valid", idx_valid, 0);
    chk_val("abort_index", eff_cycle_index, 0);
    any_done = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) any_done = 1;
    end
    chk_val("abort_no_done", any_done, 0);
    run_pass(0, 11);

    // start together with cfg_valid: chunk 0 written, no pass
    start     = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 2'd3;
    tick();
    start     = 1'b0;
    cfg_valid = 1'b0;
    chk_val("start_cfg_busy", busy, 0);
    chk_val("start_cfg_pattern", sweepstart, 32'he4e4e4e7);
    chk_val("start_cfg_loaded", cfg_loaded, 1);

    // asynchronous reset in the middle of a pass
    run_to_index(3, found);
    advance = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_val("arst_busy", busy, 0);
    chk_val("arst_idx_valid", idx_valid, 0);
    chk_val("arst_index", eff_cycle_index, 0);
    chk_val("arst_cfg_loaded", cfg_loaded, 0);
    chk_val("arst_cfg_ready", cfg_ready, 1);
    chk_val("arst_sweepstart", sweepstart, 0);

    chk_val("pz_cfg_loaded", z_cfg_loaded, 1);
    chk_val("pz_cfg_ready", z_cfg_ready, 0);
    chk_val("pz_sweepstart", z_sweepstart, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk_val("pz_cfg_loaded_run", z_cfg_loaded, 1);
    chk_val("pz_busy", z_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
